// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath/opcode widths, alu opcodes and requester IDs.
package cpu_pkg;

  localparam int unsigned ALU_W = 16;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_LSR = 3'b110,
    OP_LSL = 3'b111
  } alu_op_e;

  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_ADDR = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit alu with Z/C/N/V flags; shifts move by one bit and ignore b.
module alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             fZ,
  output logic             fC,
  output logic             fN,
  output logic             fV,
  output logic [WIDTH-1:0] o
);

  logic [WIDTH:0] w_sum;
  logic           w_c;
  logic           w_v;

  always_comb begin
    w_sum = '0;
    o     = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        o     = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (o[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // C is the carry of a + ~b + 1, i.e. set when no borrow occurs
        w_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        o     = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (o[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: o = a & b;
      OP_ORR: o = a | b;
      OP_NOT: o = ~a;
      OP_XOR: o = a ^ b;
      OP_LSR: begin
        o   = {1'b0, a[WIDTH-1:1]};
        w_c = a[0];
      end
      OP_LSL: begin
        o   = {a[WIDTH-2:0], 1'b0};
        w_c = a[WIDTH-1];
      end
      default: o = '0;
    endcase
  end

  assign fZ = (o == '0);
  assign fN = o[WIDTH-1];
  assign fC = w_c;
  assign fV = w_v;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two requesters through a
// two-stage (operand reg -> result reg) pipeline with in-order, ID-tagged responses.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH       = ALU_W,
  parameter int unsigned OPW         = OP_W,
  parameter logic        FIRST_GRANT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_o,
  output logic             rsp_fZ,
  output logic             rsp_fC,
  output logic             rsp_fN,
  output logic             rsp_fV,
  output logic             busy
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [OPW-1:0]   r_s1_op;
  logic             r_s1_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_o;
  logic             r_rsp_fz;
  logic             r_rsp_fc;
  logic             r_rsp_fn;
  logic             r_rsp_fv;
  logic             r_last_grant;

  logic             w_s1_adv;
  logic             w_s1_free;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic [WIDTH-1:0] w_alu_o;
  logic             w_alu_fz;
  logic             w_alu_fc;
  logic             w_alu_fn;
  logic             w_alu_fv;

  assign w_s1_adv  = r_s1_valid && (!r_rsp_valid || rsp_ready);
  assign w_s1_free = !r_s1_valid || w_s1_adv;

  // Each ready depends only on the other side's valid, so at most one can
  // be accepted per cycle and a collision goes to the requester not served last.
  assign w_rdy0 = rst_n && w_s1_free && (!req1_valid || r_last_grant);
  assign w_rdy1 = rst_n && w_s1_free && (!req0_valid || !r_last_grant);
  assign w_acc0 = req0_valid && w_rdy0;
  assign w_acc1 = req1_valid && w_rdy1;
  assign w_acc  = w_acc0 || w_acc1;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a  (r_s1_a),
    .b  (r_s1_b),
    .op (r_s1_op),
    .fZ (w_alu_fz),
    .fC (w_alu_fc),
    .fN (w_alu_fn),
    .fV (w_alu_fv),
    .o  (w_alu_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_op      <= '0;
      r_s1_id      <= REQ_EXEC;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= REQ_EXEC;
      r_rsp_o      <= '0;
      r_rsp_fz     <= 1'b0;
      r_rsp_fc     <= 1'b0;
      r_rsp_fn     <= 1'b0;
      r_rsp_fv     <= 1'b0;
      r_last_grant <= ~FIRST_GRANT;
    end else begin
      r_s1_valid <= w_acc || (r_s1_valid && !w_s1_adv);
      if (w_acc) begin
        r_s1_a       <= w_acc1 ? req1_a  : req0_a;
        r_s1_b       <= w_acc1 ? req1_b  : req0_b;
        r_s1_op      <= w_acc1 ? req1_op : req0_op;
        r_s1_id      <= w_acc1 ? REQ_ADDR : REQ_EXEC;
        r_last_grant <= w_acc1;
      end
      r_rsp_valid <= w_s1_adv || (r_rsp_valid && !rsp_ready);
      if (w_s1_adv) begin
        r_rsp_id <= r_s1_id;
        r_rsp_o  <= w_alu_o;
        r_rsp_fz <= w_alu_fz;
        r_rsp_fc <= w_alu_fc;
        r_rsp_fn <= w_alu_fn;
        r_rsp_fv <= w_alu_fv;
      end
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_o      = r_rsp_o;
  assign rsp_fZ     = r_rsp_fz;
  assign rsp_fC     = r_rsp_fc;
  assign rsp_fN     = r_rsp_fn;
  assign rsp_fV     = r_rsp_fv;
  assign busy       = r_s1_valid || r_rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: queue-based reference model checked every cycle,
// plus literal expectations on the observed response log.
module tb_alu_arbiter;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp_valid, rsp_id, rsp_fZ, rsp_fC, rsp_fN, rsp_fV, busy;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_o;

  always #5 clk = ~clk;

  alu_arbiter #(
    .WIDTH       (16),
    .OPW         (3),
    .FIRST_GRANT (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_o      (rsp_o),
    .rsp_fZ     (rsp_fZ),
    .rsp_fC     (rsp_fC),
    .rsp_fN     (rsp_fN),
    .rsp_fV     (rsp_fV),
    .busy       (busy)
  );

  typedef struct {
    logic        id;
    logic [15:0] o;
    logic        z, c, n, v;
    int          cyc;
  } item_t;

  item_t q[$];      // model: accepted ops not yet handed to the consumer
  item_t log_q[$];  // responses as observed at the DUT output
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  logic  lg_m;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic item_t model(input logic id, input logic [15:0] a, input logic [15:0] b,
                                  input logic [2:0] op, input int c);
    item_t r;
    int    sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r.id = id; r.cyc = c; r.c = 1'b0; r.v = 1'b0; r.o = '0;
    case (op)
      3'd0: begin r.o = a + b; r.c = (int'(a) + int'(b)) > 65535; s = sa + sb; r.v = (s > 32767) || (s < -32768); end
      3'd1: begin r.o = a - b; r.c = (a >= b); s = sa - sb; r.v = (s > 32767) || (s < -32768); end
      3'd2: r.o = a & b;
      3'd3: r.o = a | b;
      3'd4: r.o = ~a;
      3'd5: r.o = a ^ b;
      3'd6: begin r.o = a >> 1; r.c = a[0]; end
      default: begin r.o = a << 1; r.c = a[15]; end
    endcase
    r.z = (r.o == 16'd0);
    r.n = r.o[15];
    return r;
  endfunction

  // Per-cycle compare against the model, then advance the model by what the edge will do.
  initial begin : monitor
    logic  exp_rv, s1_full, free, er0, er1;
    item_t e, obs;
    lg_m = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_rv  = (q.size() > 0) && (q[0].cyc < cyc);
      s1_full = (q.size() == 2) || ((q.size() == 1) && (q[0].cyc == cyc));
      free    = !s1_full || !exp_rv || rsp_ready;
      er0     = rst_n && free && (!req1_valid || lg_m);
      er1     = rst_n && free && (!req0_valid || !lg_m);
      chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
      chk("busy", int'(busy), int'(q.size() > 0));
      chk("req0_ready", int'(req0_ready), int'(er0));
      chk("req1_ready", int'(req1_ready), int'(er1));
      if (exp_rv && rsp_valid) begin
        e = q[0];
        chk("rsp_id", int'(rsp_id), int'(e.id));
        chk("rsp_o", int'(rsp_o), int'(e.o));
        chk("rsp_flags", int'({rsp_fZ, rsp_fC, rsp_fN, rsp_fV}), int'({e.z, e.c, e.n, e.v}));
      end
      if (!rst_n) begin
        q.delete();
        lg_m = 1'b1;
      end else begin
        if (rsp_valid && rsp_ready) begin
          obs.id = rsp_id; obs.o = rsp_o; obs.cyc = cyc;
          obs.z = rsp_fZ; obs.c = rsp_fC; obs.n = rsp_fN; obs.v = rsp_fV;
          log_q.push_back(obs);
          if (exp_rv) void'(q.pop_front());
        end
        if (req0_valid && req0_ready) begin
          q.push_back(model(1'b0, req0_a, req0_b, req0_op, cyc + 1));
          lg_m = 1'b0;
        end else if (req1_valid && req1_ready) begin
          q.push_back(model(1'b1, req1_a, req1_b, req1_op, cyc + 1));
          lg_m = 1'b1;
        end
      end
    end
  end

  // Present one op on requester r and hold it until accepted; returns the acceptance cycle.
  task automatic send(input int r, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] op, output int acc_cyc);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    if (r == 1) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else        begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = (r == 1) ? req1_ready : req0_ready;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (r == 1) req1_valid = 1'b0;
    else        req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic log_chk(input int idx, input logic id, input logic [15:0] o);
    if (idx < log_q.size()) begin
      chk("log_id", int'(log_q[idx].id), int'(id));
      chk("log_o", int'(log_q[idx].o), int'(o));
    end else begin
      chk("log_missing", log_q.size(), idx + 1);
    end
  endtask

  initial begin : stim
    int ac0, ac1;
    @(negedge clk);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_o", int'(rsp_o), 0);
    chk("reset_ready0", int'(req0_ready), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: single ADD, latency one cycle after acceptance
    log_q.delete();
    send(0, 16'd1, 16'd2, OP_ADD, ac0);
    drain();
    chk("t1_count", log_q.size(), 1);
    log_chk(0, 1'b0, 16'h0003);
    if (log_q.size() > 0) begin
      chk("t1_fZ", int'(log_q[0].z), 0);
      chk("t1_latency", log_q[0].cyc, ac0 + 1);
    end

    // T2: requester 1 SUB giving zero
    log_q.delete();
    send(1, 16'd1, 16'd1, OP_SUB, ac1);
    drain();
    chk("t2_count", log_q.size(), 1);
    log_chk(0, 1'b1, 16'h0000);
    if (log_q.size() > 0) chk("t2_fZ", int'(log_q[0].z), 1);

    // T3: collisions alternate between requesters
    log_q.delete();
    fork
      send(0, 16'd6, 16'd5, OP_AND, ac0);
      send(1, 16'd6, 16'd5, OP_ORR, ac1);
    join
    chk("t3_order", int'(ac0 < ac1), 1);
    send(0, 16'd0, 16'd0, OP_ADD, ac0);
    fork
      send(0, 16'd6, 16'd5, OP_XOR, ac0);
      send(1, 16'd15, 16'd0, OP_NOT, ac1);
    join
    drain();
    chk("t3_count", log_q.size(), 5);
    log_chk(0, 1'b0, 16'h0004);
    log_chk(1, 1'b1, 16'h0007);
    log_chk(2, 1'b0, 16'h0000);
    log_chk(3, 1'b1, 16'hFFF0);
    log_chk(4, 1'b0, 16'h0003);

    // T4: backpressure with req0 streaming LSL
    log_q.delete();
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 16'(2 + i), 16'd0, OP_LSL, ac0);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_hold_o", int'(rsp_o), 4);
        chk("t4_hold_valid", int'(rsp_valid), 1);
        chk("t4_full_ready0", int'(req0_ready), 0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();
    chk("t4_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) log_chk(i, 1'b0, 16'(4 + 2 * i));

    // T5: one op per cycle
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_a = 16'(i); req0_b = 16'd1; req0_op = OP_ADD;
      @(negedge clk);
      chk("t5_ready", int'(req0_ready), 1);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    drain();
    chk("t5_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      log_chk(i, 1'b0, 16'(i + 1));
      if (i < log_q.size()) chk("t5_back_to_back", log_q[i].cyc - log_q[0].cyc, i);
    end

    // T6: reset with both stages full
    rsp_ready = 1'b0;
    send(0, 16'd7, 16'd7, OP_ADD, ac0);
    send(1, 16'd3, 16'd1, OP_SUB, ac1);
    @(negedge clk);
    chk("t6_full_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready0", int'(req0_ready), 0);
    chk("t6_rst_ready1", int'(req1_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t6_rsp_valid", int'(rsp_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_rsp_o", int'(rsp_o), 0);
    chk("t6_rsp_id", int'(rsp_id), 0);
    chk("t6_flags", int'({rsp_fZ, rsp_fC, rsp_fN, rsp_fV}), 0);
    @(posedge clk);
    #1;
    log_q.delete();
    fork
      send(0, 16'd1, 16'd2, OP_ORR, ac0);
      send(1, 16'd1, 16'd1, OP_XOR, ac1);
    join
    drain();
    chk("t6_count", log_q.size(), 2);
    log_chk(0, 1'b0, 16'h0003);
    log_chk(1, 1'b1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
